// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, forward-select encodings and the
// hazard scoreboard entry types used by hazard_controller.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       is_load;
  } ex_entry_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } mem_entry_t;

  // A source depends on a producer only if it is actually read and is not x0.
  function automatic logic src_hit(input logic used, input logic [4:0] idx,
                                   input logic v, input logic [4:0] rd);
    return used && (idx != 5'd0) && v && (idx == rd);
  endfunction

  // The EX entry is the younger producer, so it takes precedence over MEM.
  function automatic fwd_sel_e fwd_for(input logic ex_hit, input logic mem_hit);
    if (ex_hit)
      return FWD_MEM;
    else if (mem_hit)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier: which register fields an RV32I instruction
// reads or writes, and whether it is a load. Unknown opcodes do nothing.
module opcode_class_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       writes_rd,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       is_load
);

  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        is_load   = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      default: begin
        writes_rd = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: EX/MEM destination
// scoreboard, ID stall, EX bubble insertion and registered forward selects.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise any RAW hazard stalls.
module hazard_controller
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             flush,
  output logic             id_stall,
  output logic             ex_issue_valid,
  output logic [1:0]       fwd_sel_rs1,
  output logic [1:0]       fwd_sel_rs2,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       id_writes_rd;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_is_load;

  ex_entry_t  ex_q;
  mem_entry_t mem_q;

  logic       rs1_ex_hit;
  logic       rs1_mem_hit;
  logic       rs2_ex_hit;
  logic       rs2_mem_hit;
  logic       hazard;
  logic       issue;

  opcode_class_decoder u_decoder (
    .opcode    (id_opcode),
    .writes_rd (id_writes_rd),
    .uses_rs1  (id_uses_rs1),
    .uses_rs2  (id_uses_rs2),
    .is_load   (id_is_load)
  );

  always_comb begin
    rs1_ex_hit  = src_hit(id_uses_rs1, id_rs1, ex_q.v,  ex_q.rd);
    rs1_mem_hit = src_hit(id_uses_rs1, id_rs1, mem_q.v, mem_q.rd);
    rs2_ex_hit  = src_hit(id_uses_rs2, id_rs2, ex_q.v,  ex_q.rd);
    rs2_mem_hit = src_hit(id_uses_rs2, id_rs2, mem_q.v, mem_q.rd);
  end

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = ex_q.is_load && (rs1_ex_hit || rs2_ex_hit);
  end
`else
  always_comb begin
    hazard = rs1_ex_hit || rs1_mem_hit || rs2_ex_hit || rs2_mem_hit;
  end
`endif

  // Reset and flush both override a stall, so the killed slot never counts.
  always_comb begin
    id_stall = id_valid && hazard && !flush && !rst;
    issue    = id_valid && !id_stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      mem_q          <= '0;
      ex_issue_valid <= 1'b0;
    end else begin
      ex_q.v         <= issue && id_writes_rd && (id_rd != 5'd0);
      ex_q.rd        <= id_rd;
      ex_q.is_load   <= issue && id_is_load;
      mem_q.v        <= ex_q.v;
      mem_q.rd       <= ex_q.rd;
      ex_issue_valid <= issue;
    end
  end

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e fwd_rs1_q;
  fwd_sel_e fwd_rs2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end else if (issue) begin
      fwd_rs1_q <= fwd_for(rs1_ex_hit, rs1_mem_hit);
      fwd_rs2_q <= fwd_for(rs2_ex_hit, rs2_mem_hit);
    end else begin
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end
  end

  assign fwd_sel_rs1 = fwd_rs1_q;
  assign fwd_sel_rs2 = fwd_rs2_q;
`else
  assign fwd_sel_rs1 = FWD_RF;
  assign fwd_sel_rs2 = FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (id_stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_ONE;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed rows push expected outputs,
// a negedge monitor pops and compares. Expectations follow HAZARD_FORWARD_EN.
module tb_hazard_controller;

  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] NOP    = 7'h00;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        flush;
  logic        id_stall;
  logic        ex_issue_valid;
  logic [1:0]  fwd_sel_rs1;
  logic [1:0]  fwd_sel_rs2;
  logic [31:0] stall_cycles;

  typedef struct {
    int          row;
    logic        stall;
    logic        issue;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   rowId = 0;

  hazard_controller #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .flush          (flush),
    .id_stall       (id_stall),
    .ex_issue_valid (ex_issue_valid),
    .fwd_sel_rs1    (fwd_sel_rs1),
    .fwd_sel_rs2    (fwd_sel_rs2),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int row, input string name,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, actual, expected);
    end
  endtask

  // Each row drives one ID slot and states what is visible during that cycle:
  // the combinational stall plus the registered outputs of the previous edge.
  task automatic applyStimulus(input logic v, input logic [6:0] opc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic fl, input logic rs,
                               input logic e_stall, input logic e_issue,
                               input logic [1:0] e_s1, input logic [1:0] e_s2,
                               input int e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid  = v;
    id_opcode = opc;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    flush     = fl;
    rst       = rs;
    e.row   = rowId;
    e.stall = e_stall;
    e.issue = e_issue;
    e.s1    = e_s1;
    e.s2    = e_s2;
    e.cnt   = e_cnt;
    expQ.push_back(e);
    rowId++;
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e.row, "id_stall",       {31'd0, id_stall},       {31'd0, e.stall});
      checkOutput(e.row, "ex_issue_valid", {31'd0, ex_issue_valid}, {31'd0, e.issue});
      checkOutput(e.row, "fwd_sel_rs1",    {30'd0, fwd_sel_rs1},    {30'd0, e.s1});
      checkOutput(e.row, "fwd_sel_rs2",    {30'd0, fwd_sel_rs2},    {30'd0, e.s2});
      checkOutput(e.row, "stall_cycles",   stall_cycles,            e.cnt);
    end
  end

  initial begin
    int waitCycles;
    rst = 1'b1; id_valid = 1'b0; id_opcode = NOP;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with a valid load in ID: no stall, reset values.
    applyStimulus(1, LOAD, 5'd1, 5'd0, 5'd5, 0, 1,  0, 0, 2'd0, 2'd0, 0);

`ifdef HAZARD_FORWARD_EN
    // ADD x5,x1,x2 ; ADD x6,x5,x3
    applyStimulus(1, OP,   5'd1, 5'd2, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd3, 5'd6, 0, 0,  0, 1, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 1, 2'd1, 2'd0, 0);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 1,  0, 0, 2'd0, 2'd0, 0);
    // LW x5,0(x1) ; ADD x6,x5,x5
    applyStimulus(1, LOAD, 5'd1, 5'd0, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  1, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  0, 0, 2'd0, 2'd0, 1);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 1, 2'd2, 2'd2, 1);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 1,  0, 0, 2'd0, 2'd0, 1);
`else
    // ADD x5,x1,x2 ; ADD x6,x5,x3 : two stall cycles without forwarding
    applyStimulus(1, OP,   5'd1, 5'd2, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd3, 5'd6, 0, 0,  1, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd3, 5'd6, 0, 0,  1, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, OP,   5'd5, 5'd3, 5'd6, 0, 0,  0, 0, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 1, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 1,  0, 0, 2'd0, 2'd0, 2);
    // LW x5,0(x1) ; ADD x6,x5,x5
    applyStimulus(1, LOAD, 5'd1, 5'd0, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  1, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  1, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  0, 0, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 1, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 1,  0, 0, 2'd0, 2'd0, 2);
`endif

    // ADDI x0,x1,1 ; ADD x6,x0,x0 : x0 never hazards
    applyStimulus(1, OPIMM, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,    5'd0, 5'd0, 5'd6, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0);

`ifdef HAZARD_FORWARD_EN
    // ADDI x7 ; LUI x7 ; SW x7,0(x2) ; ADD x8,x7,x0 (store must not write)
    applyStimulus(1, OPIMM, 5'd1, 5'd0, 5'd7, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, LUI,   5'd7, 5'd7, 5'd7, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, STORE, 5'd2, 5'd7, 5'd7, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,    5'd7, 5'd0, 5'd8, 0, 0, 0, 1, 2'd0, 2'd1, 0);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'd2, 2'd0, 0);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
`else
    // ADDI x7 ; LUI x7 (reads nothing) ; SW x7,0(x2) stalls on EX then MEM
    applyStimulus(1, OPIMM, 5'd1, 5'd0, 5'd7, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, LUI,   5'd7, 5'd7, 5'd7, 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, STORE, 5'd2, 5'd7, 5'd7, 0, 0, 1, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, STORE, 5'd2, 5'd7, 5'd7, 0, 0, 1, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, STORE, 5'd2, 5'd7, 5'd7, 0, 0, 0, 0, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 2);
    applyStimulus(0, NOP,   5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 2'd0, 2'd0, 2);
`endif

    // Flush on the load-use slot: no stall, bubble, counter unchanged.
    applyStimulus(1, LOAD, 5'd1, 5'd0, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 1, 0,  0, 1, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 1,  0, 0, 2'd0, 2'd0, 0);

    // Reset during a stall: stall drops at once, tags discarded at the edge.
    applyStimulus(1, LOAD, 5'd1, 5'd0, 5'd5, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  1, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 1,  0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, OP,   5'd5, 5'd5, 5'd6, 0, 0,  0, 0, 2'd0, 2'd0, 0);
    applyStimulus(0, NOP,  5'd0, 5'd0, 5'd0, 0, 0,  0, 1, 2'd0, 2'd0, 0);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d rows unchecked, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It tracks the destination registers of instructions in flight in EX and MEM and compares them with the source registers of the instruction in ID. For each source operand it produces a registered forwarding select, consumed in EX to choose between the register-file value and the MEM/WB forward-data muxes. It stalls ID for one cycle on a load-use hazard and turns flushed or stalled slots into EX bubbles.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; **synchronous, active-high; one clock**.
- `id_valid`  in  1  ID holds a real instruction.
- `id_opcode`  in  7  opcode of the ID instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register fields of the ID instruction.
- `flush`  in  1  taken branch/jump resolved in EX; kills the ID instruction.
- `id_stall`  out  1  combinational; holds PC and the IF/ID register.
- `ex_issue_valid`  out  1  registered; EX holds a real instruction, not a bubble.
- `fwd_sel_rs1`, `fwd_sel_rs2`  out  2 each  registered, valid while the consumer is in EX: 00 register file, 01 MEM-stage forward data, 10 WB-stage forward data, 11 unused.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `id_stall`=1.

## Operation
- Opcode classes are decoded from `id_opcode`:
  - Writes rd: LUI, AUIPC, OP-IMM, OP, LOAD, JAL, JALR.
  - Uses rs1: all classes except LUI, AUIPC, JAL.
  - Uses rs2: OP, STORE, BRANCH.
  - Unknown opcodes: no reads, no writes.
- The scoreboard holds two entries. EX = {v, rd, is_load}. MEM = {v, rd}. An entry is valid only if its instruction writes rd and rd≠0.
- Every cycle the scoreboard advances unconditionally: EX→MEM, ID→EX. Stages below ID never stall.
- The ID→EX slot receives a bubble (v=0, `ex_issue_valid`=0) when `!id_valid`, `id_stall`, or `flush` is true.
- Hazard match for a source: the source is used, its index is nonzero, and it equals a valid entry's rd.
- Forward select for the next cycle:
  - EX-entry match → 01, since the producer will be in MEM.
  - Otherwise MEM-entry match → 10.
  - Otherwise → 00.
  - The youngest producer wins.
- WB-stage producers need no select. The register file is write-first.
- Load-use: an EX-entry match with is_load=1 asserts `id_stall`. On the next cycle the load is in MEM, and the recomputed select is 10.
- Priority: `rst` > `flush` > stall. `flush` forces `id_stall`=0. `rst` forces `id_stall`=0.
- `stall_cycles` increments on each cycle with `id_stall`=1 and saturates at all-ones.

## Timing
- `id_stall` has zero latency: it is combinational from the ID inputs and the scoreboard.
- `fwd_sel_*` and `ex_issue_valid` are updated at the clock edge that moves the consumer into EX, so their latency is 1 cycle.
- A load-use stall lasts exactly 1 cycle, because no other source of delay exists in the pipeline.
- Reset values: both scoreboard entries invalid, `ex_issue_valid`=0, `fwd_sel_rs1`=`fwd_sel_rs2`=00, `stall_cycles`=0. `id_stall`=0 while `rst`=1.
- Reset asserted mid-stall: the stall drops in the same cycle, and all in-flight tags are discarded at the edge.
- `flush` during a load-use stall: the stall is cancelled, a bubble is issued, and the counter is not incremented.
- Both sources hazarding on the same load: still a single 1-cycle stall; both selects become 10.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - Behaviour as above.
- `HAZARD_FORWARD_EN` undefined:
  - No forwarding; `fwd_sel_*` are tied to 00.
  - `id_stall` asserts on any match against a valid EX or MEM entry, whether or not the producer is a load.
  - A dependent instruction immediately after its producer therefore stalls 2 cycles.

## Structure
- Shared package `rv32i_pkg`:
  - Opcode constants (OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR).
  - Forward-select encodings FWD_RF, FWD_MEM, FWD_WB.
- One sub-module, `opcode_class_decoder`: combinational; maps the opcode to {writes_rd, uses_rs1, uses_rs2, is_load}.

## Test plan
- ADD x5,x1,x2 then ADD x6,x5,x3 back-to-back → no stall; `fwd_sel_rs1`=01 in the consumer's EX cycle; `fwd_sel_rs2`=00.
- LW x5,0(x1) then ADD x6,x5,x5 → `id_stall`=1 for 1 cycle; `ex_issue_valid`=0 on the next cycle; then both selects=10; `stall_cycles`=1.
- Producer ADDI x0,x1,1 then ADD x6,x0,x0 → no stall; selects stay 00.
- ADDI x7 in MEM and LUI x7 in EX, consumer SW x7,0(x2) → `fwd_sel_rs2`=01 (the youngest producer wins).
- LW x5, then consumer using x5 with `flush`=1 in that cycle → `id_stall`=0; bubble issued; counter unchanged. Separately, `rst` asserted during a stall → outputs return to reset values at the next edge.
- Build without `HAZARD_FORWARD_EN`: ADD x5 then ADD using x5 → `id_stall`=1 for 2 cycles; selects 00; `stall_cycles`=2.
